// File: rtl/arb_4req_rr.sv
// Four-requester round-robin arbiter with registered one-hot grant and hold-until-release.
// Optional forced release after TIMEOUT_CYCLES is built only when ARB_TIMEOUT_EN is defined.
module arb_4req_rr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout_flag
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] grant_nxt;
    logic [1:0] idx_nxt;
    logic       valid_nxt;
    logic [1:0] last, last_nxt;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       win_found;
    logic       holder_release;
    logic       timeout_hit;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("arb_4req_rr: TIMEOUT_CYCLES must be in 2..255");
    end

    // Search starts one past the previous holder; offset 4 wraps back to last itself.
    always_comb begin
        win_idx   = 2'd0;
        win_found = 1'b0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!win_found && req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    assign holder_release = done[grant_idx] | ~req[grant_idx];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       expire;
    logic       tflag_r;

    assign timeout_hit  = (hold_cnt == 8'(TIMEOUT_CYCLES));
    assign timeout_flag = tflag_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= 8'd0;
            tflag_r  <= 1'b0;
        end else begin
            tflag_r <= expire;
            if (state == IDLE) begin
                hold_cnt <= (req != 4'b0000) ? 8'd1 : 8'd0;
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        idx_nxt   = grant_idx;
        valid_nxt = grant_valid;
        last_nxt  = last;
`ifdef ARB_TIMEOUT_EN
        expire    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_nxt = GRANT;
                    grant_nxt = 4'b0001 << win_idx;
                    idx_nxt   = win_idx;
                    valid_nxt = 1'b1;
                end
            end
            GRANT: begin
                // A normal release wins over a coincident timeout, so no flag then.
                if (holder_release || timeout_hit) begin
                    state_nxt = IDLE;
                    grant_nxt = 4'b0000;
                    idx_nxt   = 2'd0;
                    valid_nxt = 1'b0;
                    last_nxt  = grant_idx;
`ifdef ARB_TIMEOUT_EN
                    expire    = ~holder_release;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 4'b0000;
                idx_nxt   = 2'd0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= 4'b0000;
            grant_idx   <= 2'd0;
            grant_valid <= 1'b0;
            last        <= 2'd3;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_idx   <= idx_nxt;
            grant_valid <= valid_nxt;
            last        <= last_nxt;
        end
    end

endmodule

// File: tb/tb_arb_4req_rr.sv
// Bench for arb_4req_rr: directed scenarios plus random traffic against a behavioural
// arbitration model; a grant-order queue cross-checks every new grant.
module tb_arb_4req_rr;

    localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] done = 4'b0000;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout_flag;

    arb_4req_rr #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .done         (done),
        .grant        (grant),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: who holds the grant (-1 none), previous holder, cycles held so far.
    int   m_holder = -1;
    int   m_last   = 3;
    int   m_len    = 0;
    bit   m_tflag  = 1'b0;
    logic prev_valid = 1'b0;

    logic [1:0] exp_q[$];
    int         obs_starts[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_step(input logic r_n, input logic [3:0] r, input logic [3:0] d);
        m_tflag = 1'b0;
        if (!r_n) begin
            m_holder = -1;
            m_last   = 3;
            m_len    = 0;
            exp_q.delete();
        end else if (m_holder < 0) begin
            if (r != 4'b0000) begin
                for (int k = 1; k <= 4; k++) begin
                    int i;
                    i = (m_last + k) % 4;
                    if (r[i]) begin
                        m_holder = i;
                        m_len    = 1;
                        exp_q.push_back(2'(i));
                        break;
                    end
                end
            end
        end else if (d[m_holder] || !r[m_holder]) begin
            m_last   = m_holder;
            m_holder = -1;
        end else if (TO_EN && m_len == TO) begin
            m_last   = m_holder;
            m_holder = -1;
            m_tflag  = 1'b1;
        end else begin
            m_len++;
        end
    endfunction

    task automatic compare_outputs();
        logic [3:0] exp_grant;
        logic [1:0] exp_idx;
        exp_grant = (m_holder >= 0) ? 4'(1 << m_holder) : 4'b0000;
        exp_idx   = (m_holder >= 0) ? 2'(m_holder) : 2'd0;
        check("grant", 8'(grant), 8'(exp_grant));
        check("grant_idx", 8'(grant_idx), 8'(exp_idx));
        check("grant_valid", 8'(grant_valid), 8'(m_holder >= 0));
        check("timeout_flag", 8'(timeout_flag), 8'(m_tflag));
        if (grant_valid && !prev_valid) begin
            obs_starts.push_back(int'(grant_idx));
            if (exp_q.size() == 0) begin
                check("sb_unexpected_grant", 8'(grant_idx), 8'hff);
            end else begin
                check("sb_order", 8'(grant_idx), 8'(exp_q.pop_front()));
            end
        end
        prev_valid = grant_valid;
    endtask

    task automatic cycle(input logic r_n, input logic [3:0] r, input logic [3:0] d);
        @(negedge clk);
        rst_n = r_n;
        req   = r;
        done  = d;
        @(posedge clk);
        model_step(r_n, r, d);
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        cycle(1'b0, 4'b0000, 4'b0000);
        cycle(1'b0, 4'b0000, 4'b0000);
    endtask

    initial begin
        int         exp_order[5];
        int         held;
        logic [3:0] r;
        logic [3:0] d;
        logic       rn;

        exp_order = '{0, 1, 2, 3, 0};

        // Reset state, then all four requesting; each holder releases after 3 cycles.
        do_reset();
        obs_starts.delete();
        for (int c = 0; c < 24; c++) begin
            d = (m_holder >= 0 && m_len == 3) ? 4'(1 << m_holder) : 4'b0000;
            cycle(1'b1, 4'b1111, d);
        end
        check("rr_start_count", 8'(obs_starts.size() >= 5), 8'd1);
        for (int i = 0; i < 5 && i < obs_starts.size(); i++) begin
            check("rr_order", 8'(obs_starts[i]), 8'(exp_order[i]));
        end
        cycle(1'b1, 4'b0000, 4'b0000);
        cycle(1'b1, 4'b0000, 4'b0000);

        // Single request from IDLE, then holder drops req.
        do_reset();
        cycle(1'b1, 4'b0100, 4'b0000);
        check("single_idx2", 8'(grant_idx), 8'd2);
        cycle(1'b1, 4'b0100, 4'b0000);
        cycle(1'b1, 4'b0000, 4'b0000);
        check("drop_release", 8'(grant), 8'd0);

        // Non-holder done is ignored; holder done releases, then a gap cycle.
        cycle(1'b1, 4'b0010, 4'b0000);
        cycle(1'b1, 4'b0010, 4'b1000);
        check("foreign_done_hold", 8'(grant), 8'h02);
        cycle(1'b1, 4'b0010, 4'b0010);
        check("own_done_release", 8'(grant_valid), 8'd0);
        cycle(1'b1, 4'b0010, 4'b0000);
        cycle(1'b1, 4'b0000, 4'b1111);

        // Reset while requester 2 holds, then 0 and 2 both request.
        cycle(1'b1, 4'b0100, 4'b0000);
        cycle(1'b1, 4'b0100, 4'b0000);
        cycle(1'b0, 4'b0100, 4'b0000);
        check("reset_abort", 8'({grant, grant_idx, grant_valid, timeout_flag}), 8'd0);
        cycle(1'b1, 4'b0101, 4'b0000);
        check("after_reset_winner", 8'(grant_idx), 8'd0);
        cycle(1'b1, 4'b0000, 4'b0000);

        // Requester 3 holds with no done while 0 also waits.
        do_reset();
        cycle(1'b1, 4'b1000, 4'b0000);
        held = 0;
        for (int c = 0; c < 110; c++) begin
            cycle(1'b1, 4'b1001, 4'b0000);
            if (grant[3]) held++;
        end
        check("hold_len", 8'(held), TO_EN ? 8'(TO - 1) : 8'd110);
        cycle(1'b1, 4'b0000, 4'b0000);
        cycle(1'b1, 4'b0000, 4'b0000);

        // Random traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            r = 4'($urandom_range(0, 15));
            if (m_holder >= 0 && $urandom_range(0, 7) != 0) r[m_holder] = 1'b1;
            d = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rn = ($urandom_range(0, 63) != 0);
            cycle(rn, r, d);
        end
        cycle(1'b1, 4'b0000, 4'b0000);
        cycle(1'b1, 4'b0000, 4'b0000);
        check("sb_drained", 8'(exp_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arb_4req_rr.md
ARB_4REQ_RR -- requirements
Module: arb_4req_rr

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, maximum grant length in cycles when ARB_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 req  input  4  request lines; bit i is requester i.
REQ-005 done  input  4  release strobes; bit i is valid only while requester i holds the grant.
REQ-006 grant  output  4  one-hot grant, registered.
REQ-007 grant_idx  output  2  binary index of the granted requester (4-to-2 encoding of grant), registered.
REQ-008 grant_valid  output  1  high while any grant bit is set.
REQ-009 timeout_flag  output  1  one-cycle pulse on forced release.

Function
REQ-010 The FSM SHALL have two states: IDLE and GRANT.
REQ-011 In IDLE with req != 0 at edge N, the block SHALL enter GRANT, and grant, grant_idx and grant_valid SHALL be valid from edge N (one-cycle latency from sampled request).
REQ-012 Arbitration SHALL be round-robin: search order starts at last+1 and wraps 3->0; the first requester with req high wins.
REQ-013 "last" SHALL update to the winner's index on every release, whether normal or forced.
REQ-014 In GRANT, the grant SHALL hold while req[grant_idx]=1 and done[grant_idx]=0; changes on other req bits SHALL be ignored.
REQ-015 In GRANT, if done[grant_idx]=1 or req[grant_idx]=0 at an edge, the block SHALL return to IDLE, and all grant outputs SHALL be 0 from that edge.
REQ-016 Consecutive grants SHALL be separated by at least one cycle with grant_valid=0.
REQ-017 done bits for non-holders, and any done bit in IDLE, SHALL be ignored.
REQ-018 When grant_valid=0, grant SHALL be 4'b0000 and grant_idx SHALL be 2'b00.
REQ-019 grant SHALL never have more than one bit set, and grant_idx SHALL always equal the encoding of grant.
REQ-020 In IDLE with req=0, the block SHALL stay in IDLE and "last" SHALL be unchanged.

Reset
REQ-021 At an edge with rst_n=0: state IDLE, grant=0, grant_idx=0, grant_valid=0, timeout_flag=0, last=3 (requester 0 highest priority), hold counter=0.
REQ-022 Reset mid-GRANT SHALL abort the grant at that edge with no timeout_flag pulse; after reset the pointer SHALL NOT reflect the aborted holder.
REQ-023 Reset SHALL take priority over all other inputs.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN defined: an 8-bit hold counter SHALL load 1 on entry to GRANT and increment each GRANT cycle.
REQ-025 With ARB_TIMEOUT_EN, when the counter equals TIMEOUT_CYCLES and no normal release occurs, the next edge SHALL force a return to IDLE, clear the grant, and set timeout_flag=1 for exactly one cycle; "last" SHALL advance to the holder.
REQ-026 With ARB_TIMEOUT_EN, a normal release in the same cycle as the timeout SHALL take precedence, and timeout_flag SHALL stay 0.
REQ-027 Macro ARB_TIMEOUT_EN undefined: no counter SHALL be built; timeout_flag SHALL be tied to 0; a grant SHALL last indefinitely.

Verification
REQ-028 Reset then req=4'b1111 -> grants in order 0,1,2,3,0 (each holder releases via done after 3 cycles), grant_idx 0,1,2,3,0.
REQ-029 req=4'b0100 sampled at edge N in IDLE -> grant=4'b0100, grant_idx=2, grant_valid=1 from edge N; holder drops req -> grant=0 at next edge.
REQ-030 Holder 1 with done=4'b1000 pulsed -> no release; then done=4'b0010 -> release, with one idle cycle before the next grant.
REQ-031 rst_n=0 during grant to requester 2 -> all outputs 0 next edge; then req=4'b0101 -> requester 0 granted.
REQ-032 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, requester 3 holds with no done -> grant high for exactly 4 cycles, then timeout_flag pulses 1 cycle and the next grant goes to the lowest pending index after 3 (wrap to 0).
REQ-033 Without ARB_TIMEOUT_EN, the same stimulus -> grant to 3 held 100+ cycles and timeout_flag remains 0.
